// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between two writeback requesters and the register-file write port.
// The master side drives requests and observes grants; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_dest;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_dest;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  reg_write_en;
    logic [ADDR_WIDTH-1:0] reg_write_dest;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic [15:0]           conflict_cnt;

    modport master (
        output req0_valid, req0_dest, req0_data,
        output req1_valid, req1_dest, req1_data,
        input  req0_ready, req1_ready,
        input  reg_write_en, reg_write_dest, reg_write_data, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_dest, req0_data,
        input  req1_valid, req1_dest, req1_data,
        output req0_ready, req1_ready,
        output reg_write_en, reg_write_dest, reg_write_data, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter: one nonzero-dest write per cycle,
// round-robin or fixed priority, registered write port and saturating conflict counter.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int RR_ENABLE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    logic                  wants0, wants1;
    logic                  grant0, grant1;
    logic                  contention;
    logic                  last_grant;
    logic                  wr_en_p1;
    logic [ADDR_WIDTH-1:0] wr_dest_p1;
    logic [DATA_WIDTH-1:0] wr_data_p1;
    logic [15:0]           conflict_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Dest-0 writes are architectural no-ops, so they never compete for the port.
    assign wants0     = bus.req0_valid && (bus.req0_dest != '0);
    assign wants1     = bus.req1_valid && (bus.req1_dest != '0);
    assign contention = wants0 && wants1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (contention) begin
                if (RR_ENABLE != 0) begin
                    grant0 = last_grant;
                    grant1 = !last_grant;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = wants0;
                grant1 = wants1;
            end
        end
    end

    assign bus.req0_ready = !rst && bus.req0_valid && ((bus.req0_dest == '0) || grant0);
    assign bus.req1_ready = !rst && bus.req1_valid && ((bus.req1_dest == '0) || grant1);

    // Stage p0 -> p1: granted write registered onto the register-file port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_p1       <= 1'b0;
            wr_dest_p1     <= '0;
            wr_data_p1     <= '0;
            last_grant     <= 1'b1;
            conflict_cnt_q <= 16'd0;
        end else begin
            wr_en_p1 <= grant0 || grant1;
            if (grant0) begin
                wr_dest_p1 <= bus.req0_dest;
                wr_data_p1 <= bus.req0_data;
                last_grant <= 1'b0;
            end else if (grant1) begin
                wr_dest_p1 <= bus.req1_dest;
                wr_data_p1 <= bus.req1_data;
                last_grant <= 1'b1;
            end
            if (contention)
                conflict_cnt_q <= sat_inc16(conflict_cnt_q);
        end
    end

    assign bus.reg_write_en   = wr_en_p1;
    assign bus.reg_write_dest = wr_dest_p1;
    assign bus.reg_write_data = wr_data_p1;
    assign bus.conflict_cnt   = conflict_cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin instance and a fixed-priority instance.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [DW-1:0] rf [0:31];

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_fp ();

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RR_ENABLE(1)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RR_ENABLE(0)) dut_fp (
        .clk(clk), .rst(rst), .bus(bus_fp.slave));

    // Reference register file fed by the round-robin instance's write port.
    always @(posedge clk)
        if (bus.reg_write_en) rf[bus.reg_write_dest] <= bus.reg_write_data;

    task automatic idle();
        bus.req0_valid = 0; bus.req0_dest = '0; bus.req0_data = '0;
        bus.req1_valid = 0; bus.req1_dest = '0; bus.req1_data = '0;
        bus_fp.req0_valid = 0; bus_fp.req0_dest = '0; bus_fp.req0_data = '0;
        bus_fp.req1_valid = 0; bus_fp.req1_dest = '0; bus_fp.req1_data = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1; bus.req0_dest = 5'd5; bus.req0_data = 32'h1234;
        bus.req1_valid = 1; bus.req1_dest = 5'd0; bus.req1_data = 32'h5678;
        @(posedge clk); #1;
        checks++; if (bus.req0_ready !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready1 got=%b exp=0", bus.req1_ready); end
        checks++; if (bus.reg_write_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b exp=0", bus.reg_write_en); end
        checks++; if (bus.reg_write_dest !== 5'd0) begin failures++; $display("FAIL reset_dest got=%0d exp=0", bus.reg_write_dest); end
        checks++; if (bus.reg_write_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.reg_write_data); end
        checks++; if (bus.conflict_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.conflict_cnt); end
        idle();
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        checks++; if (bus.reg_write_en !== 1'b0) begin failures++; $display("FAIL post_reset_en got=%b exp=0", bus.reg_write_en); end
        bus.req0_valid = 1; bus.req0_dest = 5'd5; bus.req0_data = 32'hAABBCCDD;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready0 got=%b exp=1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL single_ready1 got=%b exp=0", bus.req1_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.reg_write_en !== 1'b1) begin failures++; $display("FAIL single_en got=%b exp=1", bus.reg_write_en); end
        checks++; if (bus.reg_write_dest !== 5'd5) begin failures++; $display("FAIL single_dest got=%0d exp=5", bus.reg_write_dest); end
        checks++; if (bus.reg_write_data !== 32'hAABBCCDD) begin failures++; $display("FAIL single_data got=%h exp=aabbccdd", bus.reg_write_data); end
        @(posedge clk); #1;
        checks++; if (bus.reg_write_en !== 1'b0) begin failures++; $display("FAIL idle_en got=%b exp=0", bus.reg_write_en); end
        checks++; if (bus.reg_write_dest !== 5'd5) begin failures++; $display("FAIL idle_hold_dest got=%0d exp=5", bus.reg_write_dest); end
        checks++; if (bus.reg_write_data !== 32'hAABBCCDD) begin failures++; $display("FAIL idle_hold_data got=%h exp=aabbccdd", bus.reg_write_data); end
        checks++; if (bus.conflict_cnt !== 16'd0) begin failures++; $display("FAIL single_cnt got=%0d exp=0", bus.conflict_cnt); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_dest;
        logic [DW-1:0] exp_data;
        do_reset();
        bus.req0_valid = 1; bus.req0_dest = 5'd1; bus.req0_data = 32'h11111111;
        bus.req1_valid = 1; bus.req1_dest = 5'd2; bus.req1_data = 32'h22222222;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.req0_ready !== (k % 2 == 0)) begin failures++; $display("FAIL rr_ready0[%0d] got=%b exp=%b", k, bus.req0_ready, (k % 2 == 0)); end
            checks++; if (bus.req1_ready !== (k % 2 == 1)) begin failures++; $display("FAIL rr_ready1[%0d] got=%b exp=%b", k, bus.req1_ready, (k % 2 == 1)); end
            @(posedge clk); #1;
            exp_dest = (k % 2 == 0) ? 5'd1 : 5'd2;
            exp_data = (k % 2 == 0) ? 32'h11111111 : 32'h22222222;
            checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== exp_dest || bus.reg_write_data !== exp_data) begin
                failures++; $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, exp_dest, exp_data);
            end
            checks++; if (bus.conflict_cnt !== 16'(k + 1)) begin failures++; $display("FAIL rr_cnt[%0d] got=%0d exp=%0d", k, bus.conflict_cnt, k + 1); end
        end
        idle();
    endtask

    task automatic test_same_dest();
        do_reset();
        bus.req0_valid = 1; bus.req0_dest = 5'd3; bus.req0_data = 32'h1;
        bus.req1_valid = 1; bus.req1_dest = 5'd3; bus.req1_data = 32'h2;
        #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL same_first_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        bus.req0_valid = 0;
        checks++; if (bus.reg_write_dest !== 5'd3 || bus.reg_write_data !== 32'h1) begin failures++; $display("FAIL same_first_write got=%0d/%h exp=3/1", bus.reg_write_dest, bus.reg_write_data); end
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL same_second_ready got=%b exp=1", bus.req1_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd3 || bus.reg_write_data !== 32'h2) begin failures++; $display("FAIL same_second_write got=%b/%0d/%h exp=1/3/2", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data); end
        @(posedge clk); #1;
        checks++; if (rf[3] !== 32'h2) begin failures++; $display("FAIL same_final_reg3 got=%h exp=2", rf[3]); end
        checks++; if (bus.conflict_cnt !== 16'd1) begin failures++; $display("FAIL same_cnt got=%0d exp=1", bus.conflict_cnt); end
    endtask

    task automatic test_dest_zero();
        bus.req0_valid = 1; bus.req0_dest = 5'd0; bus.req0_data = 32'hFFFFFFFF;
        bus.req1_valid = 1; bus.req1_dest = 5'd4; bus.req1_data = 32'h44;
        #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin failures++; $display("FAIL zero_both_ready got=%b%b exp=11", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        checks++; if (bus.reg_write_en !== 1'b1 || bus.reg_write_dest !== 5'd4 || bus.reg_write_data !== 32'h44) begin failures++; $display("FAIL zero_write got=%b/%0d/%h exp=1/4/44", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data); end
        checks++; if (bus.conflict_cnt !== 16'd1) begin failures++; $display("FAIL zero_cnt got=%0d exp=1", bus.conflict_cnt); end
        // last_grant should now be 1, so the next contention goes to req0.
        bus.req0_valid = 1; bus.req0_dest = 5'd6; bus.req0_data = 32'h66;
        bus.req1_valid = 1; bus.req1_dest = 5'd7; bus.req1_data = 32'h77;
        #1;
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL zero_last_grant got=%b%b exp=10", bus.req0_ready, bus.req1_ready); end
        @(posedge clk); #1;
        idle();
        checks++; if (bus.reg_write_dest !== 5'd6 || bus.reg_write_data !== 32'h66) begin failures++; $display("FAIL zero_next_write got=%0d/%h exp=6/66", bus.reg_write_dest, bus.reg_write_data); end
        @(posedge clk); #1;
        checks++; if (rf[0] === 32'hFFFFFFFF) begin failures++; $display("FAIL zero_no_write rf0 got=%h exp=not ffffffff", rf[0]); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        bus_fp.req0_valid = 1; bus_fp.req0_dest = 5'd8; bus_fp.req0_data = 32'h80;
        bus_fp.req1_valid = 1; bus_fp.req1_dest = 5'd9; bus_fp.req1_data = 32'h90;
        for (int k = 0; k < 3; k++) begin
            bus_fp.req0_data = 32'h80 + 32'(k);
            #1;
            checks++; if (bus_fp.req0_ready !== 1'b1 || bus_fp.req1_ready !== 1'b0) begin failures++; $display("FAIL fp_ready[%0d] got=%b%b exp=10", k, bus_fp.req0_ready, bus_fp.req1_ready); end
            @(posedge clk); #1;
            checks++; if (bus_fp.reg_write_dest !== 5'd8 || bus_fp.reg_write_data !== 32'h80 + 32'(k)) begin failures++; $display("FAIL fp_write[%0d] got=%0d/%h exp=8/%h", k, bus_fp.reg_write_dest, bus_fp.reg_write_data, 32'h80 + 32'(k)); end
        end
        checks++; if (bus_fp.conflict_cnt !== 16'd3) begin failures++; $display("FAIL fp_cnt got=%0d exp=3", bus_fp.conflict_cnt); end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req1_valid = 1; bus.req1_dest = 5'd9; bus.req1_data = 32'h99;
        bus.req0_valid = 1; bus.req0_dest = 5'd10; bus.req0_data = 32'hA0;
        @(posedge clk); #1;
        checks++; if (bus.reg_write_en !== 1'b1 || bus.conflict_cnt !== 16'd1) begin failures++; $display("FAIL mid_pre_write got=%b/%0d exp=1/1", bus.reg_write_en, bus.conflict_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (bus.reg_write_en !== 1'b0) begin failures++; $display("FAIL mid_en got=%b exp=0", bus.reg_write_en); end
        checks++; if (bus.reg_write_dest !== 5'd0 || bus.reg_write_data !== 32'd0) begin failures++; $display("FAIL mid_outputs got=%0d/%h exp=0/0", bus.reg_write_dest, bus.reg_write_data); end
        checks++; if (bus.conflict_cnt !== 16'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", bus.conflict_cnt); end
        checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b%b exp=00", bus.req0_ready, bus.req1_ready); end
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.reg_write_en !== 1'b0) begin failures++; $display("FAIL mid_release_en got=%b exp=0", bus.reg_write_en); end
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_round_robin();
        test_same_dest();
        test_dest_zero();
        test_fixed_priority();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
